// File: rtl/rr_port_arbiter.sv
// rr_port_arbiter: registered arbiter for a single router output port.
// Selects one of NUM_INPUTS input channels (round-robin or fixed priority),
// holds the output locked to that channel from head flit to tail flit,
// and tracks downstream buffer credits so no flit is sent without space.

module rr_port_arbiter #(
  parameter int NUM_INPUTS = 3,
  parameter int CREDITS    = 4,
  parameter int RR_MODE    = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_INPUTS-1:0]           req,
  input  logic [NUM_INPUTS-1:0]           tail,
  input  logic                            credit_return,
  output logic [NUM_INPUTS-1:0]           grant,
  output logic [$clog2(NUM_INPUTS)-1:0]   grant_sel,
  output logic                            grant_valid,
  output logic [NUM_INPUTS-1:0]           ack,
  output logic [$clog2(CREDITS+1)-1:0]    credit_count,
  output logic                            credit_err
);

  localparam int SEL_W = $clog2(NUM_INPUTS);
  localparam int CNT_W = $clog2(CREDITS+1);
  localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(CREDITS);
  localparam logic [SEL_W-1:0] LAST_INPUT   = SEL_W'(NUM_INPUTS-1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_INPUTS-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   valid_q, valid_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_q, err_d;

  logic [SEL_W-1:0]       winner;
  logic                   xfer;
  logic                   tail_xfer;

  // A flit moves only while locked, the owner is presenting one, and space exists downstream.
  assign xfer      = (state_q == LOCKED) && req[sel_q] && (count_q != '0);
  assign tail_xfer = xfer && tail[sel_q];

  assign ack          = xfer ? grant_q : '0;
  assign grant        = grant_q;
  assign grant_sel    = sel_q;
  assign grant_valid  = valid_q;
  assign credit_count = count_q;
  assign credit_err   = err_q;

  // Pick the winning input: first requester at or after the pointer, or the highest index in fixed mode.
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] idx_sel;
    logic             found;
    winner  = '0;
    idx     = 0;
    idx_sel = '0;
    found   = 1'b0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        idx = int'(ptr_q) + i;
        if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
        idx_sel = SEL_W'(idx);
        if (!found && req[idx_sel]) begin
          winner = idx_sel;
          found  = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (req[SEL_W'(i)]) winner = SEL_W'(i);
      end
    end
  end

  // Next-state logic for the lock FSM and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          sel_d           = winner;
          valid_d         = 1'b1;
          state_d         = LOCKED;
        end
      end
      LOCKED: begin
        if (tail_xfer) begin
          grant_d = '0;
          sel_d   = '0;
          valid_d = 1'b0;
          state_d = IDLE;
          if (RR_MODE != 0) begin
            if (sel_q == LAST_INPUT) ptr_d = '0;
            else                     ptr_d = sel_q + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counter: spend one per flit, regain one per return; a return into a full counter is an error.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    case ({xfer, credit_return})
      2'b10: count_d = count_q - CNT_W'(1);
      2'b01: begin
        if (count_q == FULL_CREDITS) err_d = 1'b1;
        else                         count_d = count_q + CNT_W'(1);
      end
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops any lock and refills the credit pool.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      count_q <= FULL_CREDITS;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb_rr_port_arbiter: directed checks of the output-port arbiter.
// One round-robin instance (dut) and one fixed-priority instance (dut_fp)
// share clock and reset; every expected value below is hand-derived.

module tb_rr_port_arbiter;

  logic       clk;
  logic       reset;
  logic [2:0] req, tail;
  logic       credit_return;
  logic [2:0] grant, ack;
  logic [1:0] grant_sel;
  logic       grant_valid;
  logic [2:0] credit_count;
  logic       credit_err;

  logic [2:0] fp_req, fp_tail;
  logic       fp_credit_return;
  logic [2:0] fp_grant, fp_ack;
  logic [1:0] fp_grant_sel;
  logic       fp_grant_valid;
  logic [2:0] fp_credit_count;
  logic       fp_credit_err;

  int checks = 0;
  int errors = 0;

  rr_port_arbiter #(.NUM_INPUTS(3), .CREDITS(4), .RR_MODE(1)) dut (
    .clk(clk), .reset(reset), .req(req), .tail(tail), .credit_return(credit_return),
    .grant(grant), .grant_sel(grant_sel), .grant_valid(grant_valid), .ack(ack),
    .credit_count(credit_count), .credit_err(credit_err)
  );

  rr_port_arbiter #(.NUM_INPUTS(3), .CREDITS(4), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .req(fp_req), .tail(fp_tail), .credit_return(fp_credit_return),
    .grant(fp_grant), .grant_sel(fp_grant_sel), .grant_valid(fp_grant_valid), .ack(fp_ack),
    .credit_count(fp_credit_count), .credit_err(fp_credit_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    req = 3'b000; tail = 3'b000; credit_return = 1'b0;
    fp_req = 3'b000; fp_tail = 3'b000; fp_credit_return = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant !== 3'b000) begin errors++; $display("[TB] FAIL rst_grant: got %b want 000", grant); end
    checks++; if (grant_sel !== 2'd0) begin errors++; $display("[TB] FAIL rst_sel: got %0d want 0", grant_sel); end
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b want 0", grant_valid); end
    checks++; if (credit_count !== 3'd4) begin errors++; $display("[TB] FAIL rst_count: got %0d want 4", credit_count); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %b want 0", credit_err); end
    checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL rst_ack: got %b want 000", ack); end
    checks++; if (fp_credit_count !== 3'd4) begin errors++; $display("[TB] FAIL rst_fp_count: got %0d want 4", fp_credit_count); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_after: got %b want 0", grant_valid); end
  endtask

  // All three inputs send single-flit packets; a credit comes back with every flit.
  task automatic test_rr_rotation();
    int exp_order [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] exp_grant;
    req = 3'b111; tail = 3'b111;
    for (int p = 0; p < 6; p++) begin
      credit_return = 1'b0;
      #1;
      checks++; if (grant !== 3'b000 || ack !== 3'b000) begin errors++; $display("[TB] FAIL rr_bubble%0d: grant %b ack %b want 000/000", p, grant, ack); end
      tick();
      credit_return = 1'b1;
      #1;
      exp_grant = 3'b001 << exp_order[p];
      checks++; if (grant !== exp_grant) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b want %b", p, grant, exp_grant); end
      checks++; if (grant_sel !== 2'(exp_order[p])) begin errors++; $display("[TB] FAIL rr_sel%0d: got %0d want %0d", p, grant_sel, exp_order[p]); end
      checks++; if (ack !== exp_grant) begin errors++; $display("[TB] FAIL rr_ack%0d: got %b want %b", p, ack, exp_grant); end
      tick();
    end
    zero_inputs();
    #1;
    checks++; if (credit_count !== 3'd4) begin errors++; $display("[TB] FAIL rr_count: got %0d want 4", credit_count); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("[TB] FAIL rr_err: got %b want 0", credit_err); end
  endtask

  // in1 holds the port for a three-flit packet while in0 keeps requesting.
  task automatic test_wormhole_lock();
    do_reset();
    req = 3'b001; tail = 3'b001;
    tick();
    #1;
    checks++; if (ack !== 3'b001) begin errors++; $display("[TB] FAIL wh_warm_ack: got %b want 001", ack); end
    tick();
    req = 3'b011; tail = 3'b000;
    tick();
    #1;
    checks++; if (grant !== 3'b010 || grant_sel !== 2'd1) begin errors++; $display("[TB] FAIL wh_grant1: got %b/%0d want 010/1", grant, grant_sel); end
    checks++; if (ack !== 3'b010) begin errors++; $display("[TB] FAIL wh_ack1: got %b want 010", ack); end
    tick();
    #1;
    checks++; if (grant !== 3'b010 || ack !== 3'b010) begin errors++; $display("[TB] FAIL wh_flit2: grant %b ack %b want 010/010", grant, ack); end
    tick();
    tail = 3'b010;
    #1;
    checks++; if (grant !== 3'b010 || ack !== 3'b010) begin errors++; $display("[TB] FAIL wh_tail: grant %b ack %b want 010/010", grant, ack); end
    tick();
    req = 3'b001; tail = 3'b001;
    #1;
    checks++; if (grant !== 3'b000 || credit_count !== 3'd0) begin errors++; $display("[TB] FAIL wh_bubble: grant %b count %0d want 000/0", grant, credit_count); end
    tick();
    #1;
    checks++; if (grant !== 3'b001 || ack !== 3'b000) begin errors++; $display("[TB] FAIL wh_in0_nocredit: grant %b ack %b want 001/000", grant, ack); end
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    #1;
    checks++; if (ack !== 3'b001) begin errors++; $display("[TB] FAIL wh_in0_ack: got %b want 001", ack); end
    tick();
    zero_inputs();
    #1;
    checks++; if (grant_valid !== 1'b0 || credit_count !== 3'd0) begin errors++; $display("[TB] FAIL wh_end: valid %b count %0d want 0/0", grant_valid, credit_count); end
  endtask

  // in2 streams five flits with no returns: four go, the fifth waits for a credit.
  task automatic test_credit_starve();
    do_reset();
    req = 3'b100; tail = 3'b000;
    tick();
    for (int f = 0; f < 4; f++) begin
      #1;
      checks++; if (ack !== 3'b100 || credit_count !== 3'(4 - f)) begin errors++; $display("[TB] FAIL cs_flit%0d: ack %b count %0d want 100/%0d", f, ack, credit_count, 4 - f); end
      tick();
    end
    req = 3'b000;
    #1;
    checks++; if (grant !== 3'b100 || grant_valid !== 1'b1) begin errors++; $display("[TB] FAIL cs_lock_hold: grant %b valid %b want 100/1", grant, grant_valid); end
    checks++; if (ack !== 3'b000 || credit_count !== 3'd0) begin errors++; $display("[TB] FAIL cs_empty: ack %b count %0d want 000/0", ack, credit_count); end
    tick();
    req = 3'b100; credit_return = 1'b1;
    #1;
    checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL cs_no_ack_at_zero: got %b want 000", ack); end
    tick();
    credit_return = 1'b0; tail = 3'b100;
    #1;
    checks++; if (ack !== 3'b100 || credit_count !== 3'd1) begin errors++; $display("[TB] FAIL cs_fifth: ack %b count %0d want 100/1", ack, credit_count); end
    tick();
    zero_inputs();
    #1;
    checks++; if (grant !== 3'b000 || credit_count !== 3'd0) begin errors++; $display("[TB] FAIL cs_end: grant %b count %0d want 000/0", grant, credit_count); end
  endtask

  // Simultaneous spend and return, then a return into a full counter.
  task automatic test_credit_edge();
    credit_return = 1'b1;
    tick();
    tick();
    credit_return = 1'b0; req = 3'b001; tail = 3'b001;
    tick();
    credit_return = 1'b1;
    #1;
    checks++; if (credit_count !== 3'd2 || ack !== 3'b001) begin errors++; $display("[TB] FAIL ce_pre: count %0d ack %b want 2/001", credit_count, ack); end
    tick();
    req = 3'b000; tail = 3'b000;
    #1;
    checks++; if (credit_count !== 3'd2) begin errors++; $display("[TB] FAIL ce_same_cycle: got %0d want 2", credit_count); end
    tick();
    tick();
    #1;
    checks++; if (credit_count !== 3'd4 || credit_err !== 1'b0) begin errors++; $display("[TB] FAIL ce_full: count %0d err %b want 4/0", credit_count, credit_err); end
    tick();
    credit_return = 1'b0;
    #1;
    checks++; if (credit_count !== 3'd4 || credit_err !== 1'b1) begin errors++; $display("[TB] FAIL ce_overflow: count %0d err %b want 4/1", credit_count, credit_err); end
    tick();
    #1;
    checks++; if (credit_err !== 1'b1) begin errors++; $display("[TB] FAIL ce_sticky: got %b want 1", credit_err); end
  endtask

  // Fixed priority: the highest requesting index always wins.
  task automatic test_fixed_priority();
    fp_req = 3'b011; fp_tail = 3'b011;
    tick();
    #1;
    checks++; if (fp_grant !== 3'b010 || fp_ack !== 3'b010) begin errors++; $display("[TB] FAIL fp_first: grant %b ack %b want 010/010", fp_grant, fp_ack); end
    tick();
    fp_req = 3'b111; fp_tail = 3'b111;
    tick();
    #1;
    checks++; if (fp_grant !== 3'b100 || fp_grant_sel !== 2'd2) begin errors++; $display("[TB] FAIL fp_second: grant %b sel %0d want 100/2", fp_grant, fp_grant_sel); end
    tick();
    tick();
    fp_credit_return = 1'b1;
    #1;
    checks++; if (fp_grant !== 3'b100) begin errors++; $display("[TB] FAIL fp_starve: got %b want 100", fp_grant); end
    tick();
    fp_credit_return = 1'b0; fp_req = 3'b001; fp_tail = 3'b001;
    tick();
    #1;
    checks++; if (fp_grant !== 3'b001 || fp_ack !== 3'b001) begin errors++; $display("[TB] FAIL fp_in0: grant %b ack %b want 001/001", fp_grant, fp_ack); end
    tick();
    zero_inputs();
    #1;
    checks++; if (fp_credit_count !== 3'd1) begin errors++; $display("[TB] FAIL fp_count: got %0d want 1", fp_credit_count); end
  endtask

  // Reset asserted in the middle of an in2 packet with one credit left.
  task automatic test_reset_mid_packet();
    req = 3'b100; tail = 3'b000;
    tick();
    tick();
    tick();
    tick();
    #1;
    checks++; if (grant !== 3'b100 || credit_count !== 3'd1) begin errors++; $display("[TB] FAIL rm_pre: grant %b count %0d want 100/1", grant, credit_count); end
    reset = 1'b0;
    #1;
    checks++; if (grant !== 3'b000 || grant_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_grant: grant %b valid %b want 000/0", grant, grant_valid); end
    checks++; if (credit_count !== 3'd4 || ack !== 3'b000) begin errors++; $display("[TB] FAIL rm_count_ack: count %0d ack %b want 4/000", credit_count, ack); end
    checks++; if (credit_err !== 1'b0) begin errors++; $display("[TB] FAIL rm_err: got %b want 0", credit_err); end
    req = 3'b000;
    @(negedge clk);
    reset = 1'b1;
    tick();
    #1;
    checks++; if (grant !== 3'b000 || credit_count !== 3'd4) begin errors++; $display("[TB] FAIL rm_after: grant %b count %0d want 000/4", grant, credit_count); end
  endtask

  initial begin
    zero_inputs();
    reset = 1'b0;
    test_reset();
    test_rr_rotation();
    test_wormhole_lock();
    test_credit_starve();
    test_credit_edge();
    test_fixed_priority();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
